// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - two-read / two-write register file with write-through bypass and load scoreboard.
// Optional macro REGFILE_MP_ZERO_REG_EN hardwires register 0 to zero.
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_W-1:0]     r_addr_0,
   input  logic [ADDR_W-1:0]     r_addr_1,
   output logic [DATA_W-1:0]     r_val_0,
   output logic [DATA_W-1:0]     r_val_1,
   output logic                  r_busy_0,
   output logic                  r_busy_1,
   input  logic                  wa_en,
   input  logic [ADDR_W-1:0]     wa_addr,
   input  logic [DATA_W-1:0]     wa_data,
   input  logic                  wb_en,
   input  logic [ADDR_W-1:0]     wb_addr,
   input  logic [DATA_W-1:0]     wb_data,
   input  logic                  sb_set,
   input  logic [ADDR_W-1:0]     sb_addr,
   output logic [(2**ADDR_W)-1:0] busy_vec,
   output logic                  wr_conflict
);

   localparam int NREG = 2**ADDR_W;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [NREG-1:0]   busy_q, busy_d;
   logic              conflict_q, conflict_d;
   logic              wa_ok, wb_ok, set_ok, same_addr;
   logic [ADDR_W-1:0] rd_addr [2];

`ifdef REGFILE_MP_ZERO_REG_EN
   assign wa_ok  = wa_en  && (wa_addr != '0);
   assign wb_ok  = wb_en  && (wb_addr != '0);
   assign set_ok = sb_set && (sb_addr != '0);
`else
   assign wa_ok  = wa_en;
   assign wb_ok  = wb_en;
   assign set_ok = sb_set;
`endif

   assign same_addr = (wa_addr == wb_addr);

   // Port B is applied first so a colliding port A write overrides it.
   always_comb begin
      regs_d = regs_q;
      if (wb_ok)
         regs_d[wb_addr] = wb_data;
      if (wa_ok)
         regs_d[wa_addr] = wa_data;
   end

   // Load return clears busy even when its data lost the collision; a new issue wins over a clear.
   always_comb begin
      busy_d = busy_q;
      if (wb_en)
         busy_d[wb_addr] = 1'b0;
      if (set_ok)
         busy_d[sb_addr] = 1'b1;
   end

   assign conflict_d = wa_ok && wb_ok && same_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++)
            regs_q[i] <= '0;
         busy_q     <= '0;
         conflict_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         busy_q     <= busy_d;
         conflict_q <= conflict_d;
      end
   end

   assign rd_addr[0] = r_addr_0;
   assign rd_addr[1] = r_addr_1;

   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic [DATA_W-1:0] val;
      always_comb begin
         if (wa_en && (wa_addr == rd_addr[p]))
            val = wa_data;
         else if (wb_en && (wb_addr == rd_addr[p]))
            val = wb_data;
         else
            val = regs_q[rd_addr[p]];
`ifdef REGFILE_MP_ZERO_REG_EN
         if (rd_addr[p] == '0)
            val = '0;
`endif
      end
   end

   assign r_val_0     = g_rd[0].val;
   assign r_val_1     = g_rd[1].val;
   assign r_busy_0    = busy_q[r_addr_0];
   assign r_busy_1    = busy_q[r_addr_1];
   assign busy_vec    = busy_q;
   assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp.
module tb_regfile_mp;

   logic        clk;
   logic        rst_n;
   logic [2:0]  r_addr_0, r_addr_1;
   logic [31:0] r_val_0, r_val_1;
   logic        r_busy_0, r_busy_1;
   logic        wa_en, wb_en, sb_set;
   logic [2:0]  wa_addr, wb_addr, sb_addr;
   logic [31:0] wa_data, wb_data;
   logic [7:0]  busy_vec;
   logic        wr_conflict;

   int total;
   int bad;

   regfile_mp #(.DATA_W(32), .ADDR_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .r_addr_0(r_addr_0), .r_addr_1(r_addr_1),
      .r_val_0(r_val_0), .r_val_1(r_val_1),
      .r_busy_0(r_busy_0), .r_busy_1(r_busy_1),
      .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .sb_set(sb_set), .sb_addr(sb_addr),
      .busy_vec(busy_vec), .wr_conflict(wr_conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      wa_en = 0; wa_addr = 0; wa_data = 0;
      wb_en = 0; wb_addr = 0; wb_data = 0;
      sb_set = 0; sb_addr = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle();
      r_addr_0 = 0; r_addr_1 = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      #1;
      total++;
      if (busy_vec !== 8'h00) begin bad++; $display("FAIL reset_busy got=%h exp=00", busy_vec); end
      total++;
      if (wr_conflict !== 1'b0) begin bad++; $display("FAIL reset_conflict got=%b exp=0", wr_conflict); end
      for (int i = 0; i < 8; i++) begin
         r_addr_0 = 3'(i);
         r_addr_1 = 3'(7 - i);
         #1;
         total++;
         if (r_val_0 !== 32'h0 || r_val_1 !== 32'h0) begin
            bad++; $display("FAIL reset_read addr=%0d got=%h/%h exp=0", i, r_val_0, r_val_1);
         end
         total++;
         if (r_busy_0 !== 1'b0 || r_busy_1 !== 1'b0) begin
            bad++; $display("FAIL reset_rbusy addr=%0d got=%b%b exp=00", i, r_busy_0, r_busy_1);
         end
      end
   endtask

   task automatic test_bypass_a();
      @(negedge clk);
      wa_en = 1; wa_addr = 3; wa_data = 32'hDEADBEEF;
      r_addr_0 = 3; r_addr_1 = 4;
      #1;
      total++;
      if (r_val_0 !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_a got=%h exp=deadbeef", r_val_0); end
      total++;
      if (r_val_1 !== 32'h0) begin bad++; $display("FAIL bypass_other got=%h exp=0", r_val_1); end
      @(negedge clk);
      idle();
      #1;
      total++;
      if (r_val_0 !== 32'hDEADBEEF) begin bad++; $display("FAIL stored_a got=%h exp=deadbeef", r_val_0); end
   endtask

   task automatic test_two_ports();
      @(negedge clk);
      wa_en = 1; wa_addr = 1; wa_data = 32'h1111;
      wb_en = 1; wb_addr = 6; wb_data = 32'h6666;
      r_addr_0 = 6; r_addr_1 = 1;
      #1;
      total++;
      if (r_val_0 !== 32'h6666 || r_val_1 !== 32'h1111) begin
         bad++; $display("FAIL dual_bypass got=%h/%h exp=6666/1111", r_val_0, r_val_1);
      end
      step();
      idle();
      #1;
      total++;
      if (r_val_0 !== 32'h6666 || r_val_1 !== 32'h1111) begin
         bad++; $display("FAIL dual_stored got=%h/%h exp=6666/1111", r_val_0, r_val_1);
      end
      total++;
      if (wr_conflict !== 1'b0) begin bad++; $display("FAIL dual_no_conflict got=%b exp=0", wr_conflict); end
   endtask

   task automatic test_conflict();
      @(negedge clk);
      wa_en = 1; wa_addr = 5; wa_data = 32'h11;
      wb_en = 1; wb_addr = 5; wb_data = 32'h22;
      r_addr_0 = 5;
      #1;
      total++;
      if (r_val_0 !== 32'h11) begin bad++; $display("FAIL conflict_bypass got=%h exp=11", r_val_0); end
      step();
      idle();
      #1;
      total++;
      if (wr_conflict !== 1'b1) begin bad++; $display("FAIL conflict_flag got=%b exp=1", wr_conflict); end
      total++;
      if (r_val_0 !== 32'h11) begin bad++; $display("FAIL conflict_data got=%h exp=11", r_val_0); end
      step();
      total++;
      if (wr_conflict !== 1'b0) begin bad++; $display("FAIL conflict_clear got=%b exp=0", wr_conflict); end
   endtask

   task automatic test_scoreboard();
      @(negedge clk);
      sb_set = 1; sb_addr = 2; r_addr_0 = 2;
      step();
      idle();
      #1;
      total++;
      if (busy_vec !== 8'h04) begin bad++; $display("FAIL sb_set got=%h exp=04", busy_vec); end
      total++;
      if (r_busy_0 !== 1'b1) begin bad++; $display("FAIL sb_rbusy got=%b exp=1", r_busy_0); end
      @(negedge clk);
      wb_en = 1; wb_addr = 2; wb_data = 32'h77;
      #1;
      total++;
      if (r_val_0 !== 32'h77) begin bad++; $display("FAIL sb_wb_bypass got=%h exp=77", r_val_0); end
      total++;
      if (r_busy_0 !== 1'b1) begin bad++; $display("FAIL sb_busy_no_bypass got=%b exp=1", r_busy_0); end
      step();
      idle();
      #1;
      total++;
      if (busy_vec !== 8'h00) begin bad++; $display("FAIL sb_clear got=%h exp=00", busy_vec); end
      // Set and clear on the same register in one cycle: set wins.
      @(negedge clk);
      sb_set = 1; sb_addr = 2;
      step();
      idle();
      @(negedge clk);
      wb_en = 1; wb_addr = 2; wb_data = 32'h78;
      sb_set = 1; sb_addr = 2;
      step();
      idle();
      #1;
      total++;
      if (busy_vec !== 8'h04) begin bad++; $display("FAIL sb_set_wins got=%h exp=04", busy_vec); end
      @(negedge clk);
      wa_en = 1; wa_addr = 2; wa_data = 32'h99;
      step();
      idle();
      #1;
      total++;
      if (busy_vec !== 8'h04) begin bad++; $display("FAIL sb_porta_keeps got=%h exp=04", busy_vec); end
      @(negedge clk);
      wa_en = 1; wa_addr = 2; wa_data = 32'hA1;
      wb_en = 1; wb_addr = 2; wb_data = 32'hB2;
      step();
      idle();
      #1;
      total++;
      if (busy_vec !== 8'h00) begin bad++; $display("FAIL sb_collide_clear got=%h exp=00", busy_vec); end
      total++;
      if (r_val_0 !== 32'hA1) begin bad++; $display("FAIL sb_collide_data got=%h exp=a1", r_val_0); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      wa_en = 1; wa_addr = 7; wa_data = 32'hAA;
      sb_set = 1; sb_addr = 7;
      r_addr_0 = 7;
      step();
      idle();
      #1;
      total++;
      if (r_val_0 !== 32'hAA || busy_vec !== 8'h80) begin
         bad++; $display("FAIL rst_pre got=%h/%h exp=aa/80", r_val_0, busy_vec);
      end
      @(negedge clk);
      #2;
      rst_n = 0;
      #1;
      total++;
      if (r_val_0 !== 32'h0 || busy_vec !== 8'h00) begin
         bad++; $display("FAIL rst_async got=%h/%h exp=0/00", r_val_0, busy_vec);
      end
      wa_en = 1; wa_addr = 7; wa_data = 32'h55;
      sb_set = 1; sb_addr = 3;
      step();
      idle();
      #1;
      total++;
      if (r_val_0 !== 32'h0 || busy_vec !== 8'h00) begin
         bad++; $display("FAIL rst_write_ignored got=%h/%h exp=0/00", r_val_0, busy_vec);
      end
      @(negedge clk);
      rst_n = 1;
      wa_en = 1; wa_addr = 7; wa_data = 32'h5A;
      step();
      idle();
      #1;
      total++;
      if (r_val_0 !== 32'h5A) begin bad++; $display("FAIL rst_first_write got=%h exp=5a", r_val_0); end
   endtask

   task automatic test_zero_reg();
      logic [31:0] exp_val;
      logic [7:0]  exp_busy;
      logic        exp_conf;
`ifdef REGFILE_MP_ZERO_REG_EN
      exp_val = 32'h0; exp_busy = 8'h00; exp_conf = 1'b0;
`else
      exp_val = 32'hFF; exp_busy = 8'h01; exp_conf = 1'b1;
`endif
      @(negedge clk);
      wa_en = 1; wa_addr = 0; wa_data = 32'hFF;
      r_addr_0 = 0;
      #1;
      total++;
      if (r_val_0 !== exp_val) begin bad++; $display("FAIL zero_bypass got=%h exp=%h", r_val_0, exp_val); end
      step();
      idle();
      #1;
      total++;
      if (r_val_0 !== exp_val) begin bad++; $display("FAIL zero_stored got=%h exp=%h", r_val_0, exp_val); end
      @(negedge clk);
      sb_set = 1; sb_addr = 0;
      step();
      idle();
      #1;
      total++;
      if (busy_vec !== exp_busy) begin bad++; $display("FAIL zero_busy got=%h exp=%h", busy_vec, exp_busy); end
      @(negedge clk);
      wa_en = 1; wa_addr = 0; wa_data = 32'h3;
      wb_en = 1; wb_addr = 0; wb_data = 32'h4;
      step();
      idle();
      #1;
      total++;
      if (wr_conflict !== exp_conf) begin bad++; $display("FAIL zero_conflict got=%b exp=%b", wr_conflict, exp_conf); end
      total++;
      if (busy_vec !== 8'h00) begin bad++; $display("FAIL zero_busy_clear got=%h exp=00", busy_vec); end
   endtask

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_bypass_a();
      test_two_ports();
      test_conflict();
      test_scoreboard();
      test_reset_mid();
      test_zero_reg();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
